// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with iterative multiply/divide engine
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, priority over everything
//   start   operation request, sampled only in IDLE
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    operands (rs, rt), captured on the start edge
//   HL_W    direct write enables: [1] HI <= Hi_in, [0] LO <= Lo_in
//   Hi_in   direct HI write data
//   Lo_in   direct LO write data
//   HL_R    read select: 1 HI, 0 LO
//   HL_out  combinational read of the selected register
//   busy    engine running (WIDTH cycles)
//   done    one-cycle pulse, HI/LO hold the new result

module hilo_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       HL_W,
  input  logic [WIDTH-1:0] Hi_in,
  input  logic [WIDTH-1:0] Lo_in,
  input  logic             HL_R,
  output logic [WIDTH-1:0] HL_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;    // operation class latched at start
  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder takes the dividend's sign
  logic               div_zero;  // divisor was zero at start
  logic [WIDTH-1:0]   opb;       // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] work;      // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hi, lo;

  // Operand magnitudes; unsigned ops (op[0]=1) never see a sign bit.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One shift-add multiply step: add opb into the upper half when the
  // multiplier LSB is set, then shift the whole product right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    mul_next = work[0] ? {mul_sum, work[WIDTH-1:1]}
                       : {1'b0, work[2*WIDTH-1:1]};
  end

  // One restoring divide step: shift the next dividend bit into the
  // remainder, subtract when it fits, and shift the quotient bit in at
  // the bottom. The partial remainder is always < opb, so the shifted
  // value needs only one extra bit and the difference fits in WIDTH.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_sub   = div_shift[WIDTH-1:0] - opb;
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_next  = {div_rem, work[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] work_nxt;
  assign work_nxt = is_div ? div_next : mul_next;

  // Final sign correction applied to the last iteration's output so the
  // result lands in HI/LO on the same edge the engine finishes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = neg_res ? -work_nxt : work_nxt;
    quot_fix = neg_res ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
    rem_fix  = neg_rem ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // With a zero divisor every step subtracts nothing, so the
      // remainder path already rebuilds a; only LO needs forcing.
      res_hi = rem_fix;
      res_lo = div_zero ? '1 : quot_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  logic last_iter;
  assign last_iter = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opb      <= '0;
      work     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          // Direct writes only land in IDLE; a simultaneous start is
          // still accepted and its result overwrites both later.
          if (HL_W[1]) hi <= Hi_in;
          if (HL_W[0]) lo <= Lo_in;
          if (start) begin
            work     <= {{WIDTH{1'b0}}, a_mag};
            opb      <= b_mag;
            cnt      <= '0;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (b == '0);
          end
        end
        S_RUN: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign HL_out = HL_R ? hi : lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit

module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, HL_R;
  logic [1:0]   op, HL_W;
  logic [W-1:0] a, b, Hi_in, Lo_in, HL_out;
  logic         busy, done;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .HL_W  (HL_W),
    .Hi_in (Hi_in),
    .Lo_in (Lo_in),
    .HL_R  (HL_R),
    .HL_out(HL_out),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  int checks   = 0;
  int failures = 0;
  int elapsed;
  bit lat_ok;
  logic [W-1:0] sb_hi, sb_lo;
  logic [W-1:0] rd_hi, rd_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reads both registers inside the current low clock phase.
  task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
    HL_R = 1'b1;
    #1 h = HL_out;
    HL_R = 1'b0;
    #1 l = HL_out;
  endtask

  // Reference: plain arithmetic on the architectural definitions. Returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx, sy, q, r;
    logic [63:0]  ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return ux * uy;
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Called on a negedge with the DUT idle; returns in cycle E0+1.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    op      = 2'($urandom);
    elapsed = 1;
    lat_ok  = 1'b1;
  endtask

  // Advance one cycle while the engine must be running.
  task automatic step();
    if (!(busy === 1'b1 && done === 1'b0)) lat_ok = 1'b0;
    @(negedge clk);
    elapsed++;
  endtask

  task automatic finish_op(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
    while (elapsed <= W) step();
    check({name, " latency"}, {61'b0, lat_ok, busy, done}, 64'b101);
    read_hl(rd_hi, rd_lo);
    check({name, " HI"}, rd_hi, eh);
    check({name, " LO"}, rd_lo, el);
    sb_hi = eh;
    sb_lo = el;
  endtask

  task automatic leave_done(input string name);
    @(negedge clk);
    check({name, " done pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'd1, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    HL_W = 2'b00; Hi_in = '0; Lo_in = '0; HL_R = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy/done", {busy, done}, 2'b00);
    read_hl(rd_hi, rd_lo);
    check("reset HI", rd_hi, 0);
    check("reset LO", rd_lo, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
      leave_done($sformatf("vec%0d", i));
    end

    // Direct writes in IDLE
    HL_W = 2'b10; Hi_in = 32'h1234_5678; Lo_in = 32'hDEAD_BEEF;
    @(negedge clk);
    HL_W = 2'b00;
    read_hl(rd_hi, rd_lo);
    check("mthi HI", rd_hi, 32'h1234_5678);
    check("mthi LO kept", rd_lo, sb_lo);
    sb_hi = 32'h1234_5678;
    HL_W = 2'b01; Lo_in = 32'h0BAD_F00D; Hi_in = 32'hFFFF_0000;
    @(negedge clk);
    HL_W = 2'b00;
    read_hl(rd_hi, rd_lo);
    check("mtlo HI kept", rd_hi, sb_hi);
    check("mtlo LO", rd_lo, 32'h0BAD_F00D);
    sb_lo = 32'h0BAD_F00D;

    // Direct write while busy and while in DONE is ignored
    launch(2'd3, 32'd100, 32'd7);
    repeat (3) step();
    HL_W = 2'b11; Hi_in = 32'hAAAA_AAAA; Lo_in = 32'h5555_5555;
    step();
    HL_W = 2'b00;
    read_hl(rd_hi, rd_lo);
    check("busy write HI", rd_hi, sb_hi);
    check("busy write LO", rd_lo, sb_lo);
    finish_op("divu 100/7", 32'd2, 32'd14);
    HL_W = 2'b11;
    @(negedge clk);
    HL_W = 2'b00;
    read_hl(rd_hi, rd_lo);
    check("done write HI", rd_hi, 32'd2);
    check("done write LO", rd_lo, 32'd14);

    // Direct write together with start: write lands, result overwrites later
    HL_W = 2'b11; Hi_in = 32'hCAFE_F00D; Lo_in = 32'h0BAD_C0DE;
    launch(2'd1, 32'd6, 32'd7);
    HL_W = 2'b00;
    step();
    read_hl(rd_hi, rd_lo);
    check("start+write HI", rd_hi, 32'hCAFE_F00D);
    check("start+write LO", rd_lo, 32'h0BAD_C0DE);
    finish_op("start+write result", 32'd0, 32'd42);
    leave_done("start+write");

    // Reset in the middle of an operation
    launch(2'd3, 32'd100, 32'd7);
    while (elapsed < 10) step();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun reset busy/done", {busy, done}, 2'b00);
    read_hl(rd_hi, rd_lo);
    check("midrun reset HI", rd_hi, 0);
    check("midrun reset LO", rd_lo, 0);
    launch(2'd1, 32'd6, 32'd7);
    finish_op("after reset multu", 32'd0, 32'd42);
    leave_done("after reset");

    // start during RUN is ignored; back-to-back after done accepted
    launch(2'd1, 32'd3, 32'd5);
    repeat (4) step();
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    finish_op("multu 3x5 restart", 32'd0, 32'd15);
    @(negedge clk);
    launch(2'd1, 32'd9, 32'd9);
    finish_op("multu 9x9 b2b", 32'd0, 32'd81);
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("start in DONE ignored", {busy, done}, 2'b00);
    @(negedge clk);
    check("start in DONE idle", {busy, done}, 2'b00);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      logic [63:0]  exp;
      ro = 2'($urandom_range(0, 3));
      rx = (i % 7 == 3) ? 32'h8000_0000 : W'($urandom);
      case ($urandom_range(0, 5))
        0:       ry = '0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = W'($urandom_range(1, 15));
        default: ry = W'($urandom);
      endcase
      exp = model(ro, rx, ry);
      launch(ro, rx, ry);
      finish_op($sformatf("rand%0d op=%0d a=%h b=%h", i, ro, rx, ry), exp[63:32], exp[31:0]);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
